adc_seq_ctrl: RTL and testbench

ADC_SEQ_CTRL -- requirements
Module: adc_seq_ctrl

---
 rtl/adc_seq_ctrl.sv | 175 +++++++++++++++++
 tb/tb_adc_seq_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_seq_ctrl.sv
// Sequencer for an LT5534 detector feeding a serial 8-bit ADC: it powers up the detector,
// waits for it to settle, then clocks 16-bit frames out of the ADC and publishes the result byte.
module adc_seq_ctrl #(
  parameter int unsigned CLK_DIV       = 2,
  parameter int unsigned WARMUP_CYCLES = 50,
  parameter int unsigned QUIET_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  output logic       lt5534_en,
  output logic       adc_cs,
  output logic       adc_clk,
  input  logic       adc_so,
  output logic [7:0] sample,
  output logic       sample_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle,
    StWarmup,
    StCsSetup,
    StShift,
    StQuiet
  } state_e;

  localparam logic [15:0] WarmLast  = 16'(WARMUP_CYCLES - 1);
  localparam logic [7:0]  HalfLast  = 8'(CLK_DIV - 1);
  localparam logic [7:0]  QuietLast = 8'(QUIET_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] warm_cnt_q, warm_cnt_d;
  logic [7:0]  half_cnt_q, half_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  quiet_cnt_q, quiet_cnt_d;
  logic [15:0] shift_q, shift_d;
  logic        en_q, en_d;
  logic        cs_q, cs_d;
  logic        aclk_q, aclk_d;
  logic [7:0]  sample_q, sample_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    warm_cnt_d  = warm_cnt_q;
    half_cnt_d  = half_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    quiet_cnt_d = quiet_cnt_q;
    shift_d     = shift_q;
    en_d        = en_q;
    cs_d        = cs_q;
    aclk_d      = aclk_q;
    sample_d    = sample_q;
    valid_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run) begin
          state_d    = StWarmup;
          en_d       = 1'b1;
          warm_cnt_d = '0;
        end
      end

      StWarmup: begin
        if (!run) begin
          state_d    = StIdle;
          en_d       = 1'b0;
          warm_cnt_d = '0;
        end else if (warm_cnt_q == WarmLast) begin
          state_d    = StCsSetup;
          cs_d       = 1'b0;
          warm_cnt_d = '0;
        end else begin
          warm_cnt_d = warm_cnt_q + 16'd1;
        end
      end

      StCsSetup: begin
        state_d    = StShift;
        aclk_d     = 1'b0;
        half_cnt_d = '0;
        bit_cnt_d  = '0;
      end

      // adc_clk_q doubles as the phase flag: 0 = low half, 1 = high half.
      StShift: begin
        if (half_cnt_q != HalfLast) begin
          half_cnt_d = half_cnt_q + 8'd1;
        end else begin
          half_cnt_d = '0;
          if (!aclk_q) begin
            aclk_d  = 1'b1;
            shift_d = {shift_q[14:0], adc_so};
          end else if (bit_cnt_q == 4'd15) begin
            state_d     = StQuiet;
            cs_d        = 1'b1;
            bit_cnt_d   = '0;
            quiet_cnt_d = '0;
            // Frame is 3 leading zeros, 8 data bits, 5 trailing don't-care bits.
            sample_d    = shift_q[12:5];
            valid_d     = 1'b1;
          end else begin
            aclk_d    = 1'b0;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end

      StQuiet: begin
        if (quiet_cnt_q != QuietLast) begin
          quiet_cnt_d = quiet_cnt_q + 8'd1;
        end else begin
          quiet_cnt_d = '0;
          if (run) begin
            state_d = StCsSetup;
            cs_d    = 1'b0;
          end else begin
            state_d = StIdle;
            en_d    = 1'b0;
          end
        end
      end

      default: begin
        state_d = StIdle;
        en_d    = 1'b0;
        cs_d    = 1'b1;
        aclk_d  = 1'b1;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      warm_cnt_q  <= '0;
      half_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      quiet_cnt_q <= '0;
      shift_q     <= '0;
      en_q        <= 1'b0;
      cs_q        <= 1'b1;
      aclk_q      <= 1'b1;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      warm_cnt_q  <= warm_cnt_d;
      half_cnt_q  <= half_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      quiet_cnt_q <= quiet_cnt_d;
      shift_q     <= shift_d;
      en_q        <= en_d;
      cs_q        <= cs_d;
      aclk_q      <= aclk_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
    end
  end

  assign lt5534_en    = en_q;
  assign adc_cs       = cs_q;
  assign adc_clk      = aclk_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Directed bench for adc_seq_ctrl: one instance at default timing, one at the fastest timing,
// each with a serial ADC model and a scoreboard of expected result bytes.
module tb_adc_seq_ctrl;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       reset0, run0, so0, en0, cs0, aclk0, valid0, busy0;
  logic [7:0] sample0;
  logic       reset1, run1, so1, en1, cs1, aclk1, valid1, busy1;
  logic [7:0] sample1;

  int tests = 0;
  int fails = 0;
  int vcnt0 = 0;
  int vcnt1 = 0;

  adc_seq_ctrl u_dut0 (
    .clk          (clk),
    .reset        (reset0),
    .run          (run0),
    .lt5534_en    (en0),
    .adc_cs       (cs0),
    .adc_clk      (aclk0),
    .adc_so       (so0),
    .sample       (sample0),
    .sample_valid (valid0),
    .busy         (busy0)
  );

  adc_seq_ctrl #(
    .CLK_DIV       (1),
    .WARMUP_CYCLES (1),
    .QUIET_CYCLES  (1)
  ) u_dut1 (
    .clk          (clk),
    .reset        (reset1),
    .run          (run1),
    .lt5534_en    (en1),
    .adc_cs       (cs1),
    .adc_clk      (aclk1),
    .adc_so       (so1),
    .sample       (sample1),
    .sample_valid (valid1),
    .busy         (busy1)
  );

  // ADC models: a frame word is loaded on adc_cs falling and shifted MSB first per adc_clk rise.
  logic [15:0] words0[$];
  logic [15:0] words1[$];
  logic [7:0]  exp0[$];
  logic [7:0]  exp1[$];
  logic [15:0] cur0 = '0;
  logic [15:0] cur1 = '0;
  logic [15:0] sr0 = '0;
  logic [15:0] sr1 = '0;

  assign so0 = sr0[15];
  assign so1 = sr1[15];

  always @(negedge cs0) begin
    if (words0.size() > 0) cur0 = words0.pop_front();
    sr0 <= cur0;
    exp0.push_back(cur0[12:5]);
  end
  always @(posedge aclk0) sr0 <= {sr0[14:0], 1'b0};

  always @(negedge cs1) begin
    if (words1.size() > 0) cur1 = words1.pop_front();
    sr1 <= cur1;
    exp1.push_back(cur1[12:5]);
  end
  always @(posedge aclk1) sr1 <= {sr1[14:0], 1'b0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (valid0 === 1'b1) begin
      vcnt0++;
      chk("sb0_expected_pending", 32'(exp0.size() > 0), 32'd1);
      if (exp0.size() > 0) chk("sb0_sample", 32'(sample0), 32'(exp0.pop_front()));
    end
    if (valid1 === 1'b1) begin
      vcnt1++;
      chk("sb1_expected_pending", 32'(exp1.size() > 0), 32'd1);
      if (exp1.size() > 0) chk("sb1_sample", 32'(sample1), 32'(exp1.pop_front()));
    end
  end

  task automatic tick(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  // Advance until the selected DUT pulses sample_valid (bounded), gathering activity statistics.
  task automatic wait_valid(input bit sel, input int bound, output int n, output int cs_hi,
                            output int toggles, output int en_lo);
    logic prev;
    n = 0; cs_hi = 0; toggles = 0; en_lo = 0;
    do begin
      prev = sel ? aclk1 : aclk0;
      @(negedge clk);
      n++;
      if ((sel ? cs1 : cs0) === 1'b1) cs_hi++;
      if ((sel ? en1 : en0) !== 1'b1) en_lo++;
      if ((sel ? aclk1 : aclk0) !== prev) toggles++;
    end while ((sel ? valid1 : valid0) !== 1'b1 && n < bound);
  endtask

  task automatic wait_rises(input int count, input int bound, output int r);
    logic prev;
    int n;
    r = 0; n = 0;
    while (r < count && n < bound) begin
      prev = aclk0;
      @(negedge clk);
      n++;
      if (prev === 1'b0 && aclk0 === 1'b1) r++;
    end
  endtask

  int n, ch, tg, el, r, v, cs_lo;

  initial begin
    reset0 = 1'b1; run0 = 1'b0;
    reset1 = 1'b1; run1 = 1'b0;
    words0.push_back(16'b000_10110011_00000);
    tick(3);
    chk("rst_en", 32'(en0), 32'd0);
    chk("rst_cs", 32'(cs0), 32'd1);
    chk("rst_adc_clk", 32'(aclk0), 32'd1);
    chk("rst_sample", 32'(sample0), 32'h00);
    chk("rst_valid", 32'(valid0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);

    // First frame from reset with run held high
    reset0 = 1'b0; run0 = 1'b1;
    n = 0;
    while (en0 !== 1'b1 && n < 10) begin tick(1); n++; end
    chk("en_rise_latency", 32'(n), 32'd1);
    chk("warmup_busy", 32'(busy0), 32'd1);
    chk("warmup_cs_high", 32'(cs0), 32'd1);
    n = 0;
    while (cs0 !== 1'b0 && n < 100) begin tick(1); n++; end
    chk("warmup_len", 32'(n), 32'd50);
    wait_valid(1'b0, 200, n, ch, tg, el);
    chk("first_frame_len", 32'(n), 32'd65);
    chk("first_sample", 32'(sample0), 32'hB3);

    // Four more back-to-back frames
    for (int k = 0; k < 4; k++) begin
      wait_valid(1'b0, 200, n, ch, tg, el);
      chk("frame_period", 32'(n), 32'd67);
      chk("quiet_cs_high", 32'(ch), 32'd2);
      chk("en_held", 32'(el), 32'd0);
    end
    chk("sample_hold_b3", 32'(sample0), 32'hB3);

    // Drop run after the 4th adc_clk rise of the next frame
    wait_rises(4, 200, r);
    chk("rise4_seen", 32'(r), 32'd4);
    run0 = 1'b0;
    wait_valid(1'b0, 200, n, ch, tg, el);
    chk("drop_frame_done", 32'(valid0), 32'd1);
    tick(2);
    chk("drop_idle_en", 32'(en0), 32'd0);
    chk("drop_idle_busy", 32'(busy0), 32'd0);
    chk("drop_idle_cs", 32'(cs0), 32'd1);
    v = vcnt0;
    tick(30);
    chk("drop_valid_count", 32'(vcnt0), 32'd6);
    chk("drop_no_more_valid", 32'(vcnt0), 32'(v));
    chk("idle_sample_hold", 32'(sample0), 32'hB3);

    // Reset mid-SHIFT
    words0.push_back(16'b000_11111111_00000);
    run0 = 1'b1;
    n = 0;
    while (cs0 !== 1'b0 && n < 100) begin tick(1); n++; end
    chk("abort_cs_fall", 32'(cs0), 32'd0);
    wait_rises(8, 100, r);
    chk("abort_rise8_seen", 32'(r), 32'd8);
    reset0 = 1'b1; run0 = 1'b0;
    tick(1);
    reset0 = 1'b0;
    chk("abort_en", 32'(en0), 32'd0);
    chk("abort_cs", 32'(cs0), 32'd1);
    chk("abort_adc_clk", 32'(aclk0), 32'd1);
    chk("abort_sample", 32'(sample0), 32'h00);
    chk("abort_valid", 32'(valid0), 32'd0);
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_pending", 32'(exp0.size()), 32'd1);
    exp0.delete();
    tick(100);
    chk("abort_no_valid", 32'(vcnt0), 32'd6);
    chk("abort_sample_held", 32'(sample0), 32'h00);

    // Short run pulse inside WARMUP
    cs_lo = 0;
    run0 = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(1); if (cs0 !== 1'b1) cs_lo++; end
    chk("pulse_en_on", 32'(en0), 32'd1);
    run0 = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(1); if (cs0 !== 1'b1) cs_lo++; end
    chk("pulse_cs_quiet", 32'(cs_lo), 32'd0);
    chk("pulse_en_off", 32'(en0), 32'd0);
    chk("pulse_busy_off", 32'(busy0), 32'd0);
    chk("pulse_no_valid", 32'(vcnt0), 32'd6);

    // Fastest timing instance
    words1.push_back(16'b000_11111111_00000);
    words1.push_back(16'b000_00000000_11111);
    reset1 = 1'b0; run1 = 1'b1;
    wait_valid(1'b1, 200, n, ch, tg, el);
    chk("fast_sample_ff", 32'(sample1), 32'hFF);
    wait_valid(1'b1, 100, n, ch, tg, el);
    chk("fast_period", 32'(n), 32'd34);
    chk("fast_toggles", 32'(tg), 32'd32);
    chk("fast_cs_high", 32'(ch), 32'd1);
    chk("fast_sample_00", 32'(sample1), 32'h00);
    run1 = 1'b0;
    tick(3);
    chk("fast_idle_busy", 32'(busy1), 32'd0);
    chk("fast_idle_en", 32'(en1), 32'd0);
    chk("fast_valid_count", 32'(vcnt1), 32'd2);

    chk("sb0_drained", 32'(exp0.size()), 32'd0);
    chk("sb1_drained", 32'(exp1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
